// File: rtl/vga_scene_renderer.sv
// Three-stage pixel colour pipeline: rectangle table lookup, 16x16 sprite overlay,
// and a frame-counted fade tint toward a game-over or win colour.
module vga_scene_renderer #(
    parameter int unsigned NUM_RECTS = 16,
    parameter int unsigned COORD_W = 10,
    parameter int unsigned COLOR_W = 8,
    parameter logic [3*COLOR_W-1:0] BG_COLOR = 24'hC0C0C0,
    parameter logic [3*COLOR_W-1:0] SPRITE_COLOR = 24'h0000FF,
    parameter logic [255:0] SPRITE_MASK = 256'h0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [COORD_W-1:0]           pix_x,
    input  logic [COORD_W-1:0]           pix_y,
    input  logic                         pix_active,
    input  logic                         frame_start,
    input  logic [COORD_W-1:0]           player_x,
    input  logic [COORD_W-1:0]           player_y,
    input  logic [2:0]                   game_state,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_RECTS)-1:0] wr_idx,
    input  logic [COORD_W-1:0]           wr_x0,
    input  logic [COORD_W-1:0]           wr_x1,
    input  logic [COORD_W-1:0]           wr_y0,
    input  logic [COORD_W-1:0]           wr_y1,
    input  logic [3*COLOR_W-1:0]         wr_color,
    input  logic                         wr_vld,
    output logic [COLOR_W-1:0]           vga_r,
    output logic [COLOR_W-1:0]           vga_g,
    output logic [COLOR_W-1:0]           vga_b,
    output logic                         active_out
);

    localparam logic [2:0] STATE_RUNNING   = 3'd0;
    localparam logic [2:0] STATE_GAME_OVER = 3'd1;
    localparam logic [2:0] STATE_WIN       = 3'd2;
    localparam logic [2:0] K_MAX           = 3'd4;

    // Tint targets are given as 8-bit channels; rescale them to COLOR_W.
    function automatic logic [COLOR_W-1:0] scale8(input int unsigned v);
        return COLOR_W'((v * ((1 << COLOR_W) - 1)) / 255);
    endfunction

    function automatic logic [COLOR_W-1:0] blend(input logic [COLOR_W-1:0] base,
                                                 input logic [COLOR_W-1:0] tgt,
                                                 input logic [2:0]         k);
        logic [COLOR_W+2:0] acc;
        acc = (COLOR_W+3)'(base) * (COLOR_W+3)'(K_MAX - k) + (COLOR_W+3)'(tgt) * (COLOR_W+3)'(k);
        return acc[COLOR_W+1:2];
    endfunction

    // Rectangle table
    logic [COORD_W-1:0]   rect_x0 [NUM_RECTS];
    logic [COORD_W-1:0]   rect_x1 [NUM_RECTS];
    logic [COORD_W-1:0]   rect_y0 [NUM_RECTS];
    logic [COORD_W-1:0]   rect_y1 [NUM_RECTS];
    logic [3*COLOR_W-1:0] rect_color [NUM_RECTS];
    logic [NUM_RECTS-1:0] rect_vld_q;

    logic wr_ok;
    assign wr_ok = wr_en && (int'(wr_idx) < int'(NUM_RECTS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rect_vld_q <= '0;
        end else if (wr_ok) begin
            rect_vld_q[wr_idx] <= wr_vld;
        end
    end

    // Geometry needs no reset: entries are masked by rect_vld_q until written.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            rect_x0[wr_idx]    <= wr_x0;
            rect_x1[wr_idx]    <= wr_x1;
            rect_y0[wr_idx]    <= wr_y0;
            rect_y1[wr_idx]    <= wr_y1;
            rect_color[wr_idx] <= wr_color;
        end
    end

    // Per-frame state: sprite shadow position, fade level, latched game state
    logic [COORD_W-1:0] spr_x_q, spr_y_q;
    logic [2:0]         k_q;
    logic [2:0]         state_q;
    logic               running;

    assign running = (game_state != STATE_GAME_OVER) && (game_state != STATE_WIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spr_x_q <= '0;
            spr_y_q <= '0;
            k_q     <= '0;
            state_q <= STATE_RUNNING;
        end else if (frame_start) begin
            spr_x_q <= player_x;
            spr_y_q <= player_y;
            state_q <= game_state;
            if (running) begin
                k_q <= '0;
            end else if (k_q < K_MAX) begin
                k_q <= k_q + 3'd1;
            end
        end
    end

    // Stage 1: register pixel
    logic [COORD_W-1:0] s1_x_q, s1_y_q;
    logic               s1_active_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_active_q <= 1'b0;
        end else begin
            s1_x_q      <= pix_x;
            s1_y_q      <= pix_y;
            s1_active_q <= pix_active;
        end
    end

    // Stage 2: table priority select and sprite hit
    logic [3*COLOR_W-1:0] hit_color;
    logic [COORD_W:0]     spr_dx, spr_dy;
    logic                 spr_hit;

    always_comb begin
        hit_color = BG_COLOR;
        // Ascending scan so the highest hitting index wins.
        for (int i = 0; i < int'(NUM_RECTS); i++) begin
            if (rect_vld_q[i] &&
                s1_x_q >= rect_x0[i] && s1_x_q <= rect_x1[i] &&
                s1_y_q >= rect_y0[i] && s1_y_q <= rect_y1[i]) begin
                hit_color = rect_color[i];
            end
        end
    end

    always_comb begin
        spr_dx  = {1'b0, s1_x_q} - {1'b0, spr_x_q};
        spr_dy  = {1'b0, s1_y_q} - {1'b0, spr_y_q};
        spr_hit = (spr_dx[COORD_W:4] == '0) && (spr_dy[COORD_W:4] == '0) &&
                  SPRITE_MASK[{spr_dy[3:0], spr_dx[3:0]}];
    end

    logic [3*COLOR_W-1:0] s2_color_q;
    logic                 s2_sprite_q;
    logic                 s2_active_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_color_q  <= '0;
            s2_sprite_q <= 1'b0;
            s2_active_q <= 1'b0;
        end else begin
            s2_color_q  <= hit_color;
            s2_sprite_q <= spr_hit;
            s2_active_q <= s1_active_q;
        end
    end

    // Stage 3: overlay, tint, blanking
    logic [3*COLOR_W-1:0] base, tgt;
    logic [COLOR_W-1:0]   r_d, g_d, b_d;

    always_comb begin
        base = s2_sprite_q ? SPRITE_COLOR : s2_color_q;
        unique case (state_q)
            STATE_GAME_OVER: tgt = {scale8(255), scale8(0), scale8(0)};
            STATE_WIN:       tgt = {scale8(255), scale8(215), scale8(0)};
            default:         tgt = base;
        endcase
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (s2_active_q) begin
            r_d = blend(base[3*COLOR_W-1 -: COLOR_W], tgt[3*COLOR_W-1 -: COLOR_W], k_q);
            g_d = blend(base[2*COLOR_W-1 -: COLOR_W], tgt[2*COLOR_W-1 -: COLOR_W], k_q);
            b_d = blend(base[COLOR_W-1:0], tgt[COLOR_W-1:0], k_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_r      <= '0;
            vga_g      <= '0;
            vga_b      <= '0;
            active_out <= 1'b0;
        end else begin
            vga_r      <= r_d;
            vga_g      <= g_d;
            vga_b      <= b_d;
            active_out <= s2_active_q;
        end
    end

endmodule

// File: tb/tb_vga_scene_renderer.sv
// Directed table-driven bench for vga_scene_renderer: table lookup, sprite, fade,
// reset and same-cycle table write corner cases.
module tb_vga_scene_renderer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  pix_x = '0, pix_y = '0;
    logic        pix_active = 1'b0;
    logic        frame_start = 1'b0;
    logic [9:0]  player_x = '0, player_y = '0;
    logic [2:0]  game_state = '0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_idx = '0;
    logic [9:0]  wr_x0 = '0, wr_x1 = '0, wr_y0 = '0, wr_y1 = '0;
    logic [23:0] wr_color = '0;
    logic        wr_vld = 1'b0;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        active_out;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vga_scene_renderer #(
        .NUM_RECTS   (16),
        .COORD_W     (10),
        .COLOR_W     (8),
        .BG_COLOR    (24'hC0C0C0),
        .SPRITE_COLOR(24'h0000FF),
        .SPRITE_MASK (256'h8000_0001)   // (0,0) and (15,1) opaque
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_active (pix_active),
        .frame_start(frame_start),
        .player_x   (player_x),
        .player_y   (player_y),
        .game_state (game_state),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_x0      (wr_x0),
        .wr_x1      (wr_x1),
        .wr_y0      (wr_y0),
        .wr_y1      (wr_y1),
        .wr_color   (wr_color),
        .wr_vld     (wr_vld),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .active_out (active_out)
    );

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        act;
        logic [23:0] rgb;
        logic        eact;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int x, input int y, input logic act,
                                input logic [23:0] rgb, input logic eact);
        vec_t v;
        v.x = 10'(x); v.y = 10'(y); v.act = act; v.rgb = rgb; v.eact = eact;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [24:0] exp);
        logic [24:0] got;
        got = {active_out, vga_r, vga_g, vga_b};
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got act=%b rgb=%06h, expected act=%b rgb=%06h",
                     name, got[24], got[23:0], exp[24], exp[23:0]);
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            pix_x = vecs[i].x; pix_y = vecs[i].y; pix_active = vecs[i].act;
            repeat (3) @(posedge clk);
            #1 check($sformatf("vec%0d(%0d,%0d)", i, vecs[i].x, vecs[i].y),
                     {vecs[i].eact, vecs[i].rgb});
        end
    endtask

    task automatic write_rect(input int idx, input int x0, input int x1, input int y0,
                              input int y1, input logic [23:0] c, input logic v);
        @(negedge clk);
        wr_en = 1'b1; wr_idx = 4'(idx);
        wr_x0 = 10'(x0); wr_x1 = 10'(x1); wr_y0 = 10'(y0); wr_y1 = 10'(y1);
        wr_color = c; wr_vld = v;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_frame(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
    endtask

    initial begin
        // 0-1: empty table, RUNNING
        add(100, 100, 1'b1, 24'hC0C0C0, 1'b1);
        add(100, 100, 1'b0, 24'h000000, 1'b0);
        // 2-8: rectangles idx2 / idx5 and degenerate idx7
        add(55, 372, 1'b1, 24'hFF4500, 1'b1);
        add(10, 365, 1'b1, 24'h505050, 1'b1);
        add(61, 365, 1'b1, 24'hC0C0C0, 1'b1);
        add(100, 375, 1'b1, 24'hFF4500, 1'b1);
        add(101, 375, 1'b1, 24'hC0C0C0, 1'b1);
        add(60, 380, 1'b1, 24'h505050, 1'b1);
        add(150, 10, 1'b1, 24'hC0C0C0, 1'b1);
        // 9-12: sprite latched at (200,200)
        add(200, 200, 1'b1, 24'h0000FF, 1'b1);
        add(201, 200, 1'b1, 24'hC0C0C0, 1'b1);
        add(215, 201, 1'b1, 24'h0000FF, 1'b1);
        add(216, 201, 1'b1, 24'hC0C0C0, 1'b1);
        // 13-14: player moved without frame_start
        add(200, 200, 1'b1, 24'h0000FF, 1'b1);
        add(300, 300, 1'b1, 24'hC0C0C0, 1'b1);
        // 15-19: GAME_OVER fade k=1,2,4,4(sat), then RUNNING
        add(100, 100, 1'b1, 24'hCF9090, 1'b1);
        add(100, 100, 1'b1, 24'hDF6060, 1'b1);
        add(100, 100, 1'b1, 24'hFF0000, 1'b1);
        add(100, 100, 1'b1, 24'hFF0000, 1'b1);
        add(100, 100, 1'b1, 24'hC0C0C0, 1'b1);
        // 20-21: WIN k=1, k=4
        add(100, 100, 1'b1, 24'hCFC590, 1'b1);
        add(100, 100, 1'b1, 24'hFFD700, 1'b1);
        // 22-24: after reset: table cleared, sprite shadow at (0,0)
        add(55, 372, 1'b1, 24'hC0C0C0, 1'b1);
        add(0, 0, 1'b1, 24'h0000FF, 1'b1);
        add(200, 200, 1'b1, 24'hC0C0C0, 1'b1);

        repeat (2) @(posedge clk);
        #1 check("reset_state", 25'h0);
        @(negedge clk);
        rst = 1'b0;

        run_vecs(0, 1);

        write_rect(2, 0, 60, 360, 380, 24'h505050, 1'b1);
        write_rect(5, 50, 100, 370, 375, 24'hFF4500, 1'b1);
        write_rect(7, 200, 100, 0, 20, 24'h123456, 1'b1);
        write_rect(8, 140, 160, 0, 20, 24'h654321, 1'b0);
        run_vecs(2, 8);

        player_x = 10'd200; player_y = 10'd200;
        pulse_frame(1);
        run_vecs(9, 12);
        player_x = 10'd300; player_y = 10'd300;
        run_vecs(13, 14);

        game_state = 3'd1;
        pulse_frame(1); run_vecs(15, 15);
        pulse_frame(1); run_vecs(16, 16);
        pulse_frame(2); run_vecs(17, 17);
        pulse_frame(1); run_vecs(18, 18);
        game_state = 3'd0;
        pulse_frame(1); run_vecs(19, 19);

        game_state = 3'd2;
        pulse_frame(1); run_vecs(20, 20);
        pulse_frame(4); run_vecs(21, 21);

        // Asynchronous reset mid-frame; outputs must clear before any clock edge
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check("rst_async_clear", 25'h0);
        game_state = 3'd0;
        @(negedge clk);
        pix_x = 10'd100; pix_y = 10'd100; pix_active = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("first_out_not_yet", 25'h0);
        @(posedge clk);
        #1 check("first_out_latency", {1'b1, 24'hC0C0C0});
        run_vecs(22, 24);

        // Same-edge write to idx3 while a matching pixel enters stage 2
        write_rect(3, 390, 410, 5, 15, 24'h111111, 1'b1);
        @(negedge clk);
        pix_x = 10'd400; pix_y = 10'd10; pix_active = 1'b1;
        @(negedge clk);
        wr_en = 1'b1; wr_idx = 4'd3;
        wr_x0 = 10'd390; wr_x1 = 10'd410; wr_y0 = 10'd5; wr_y1 = 10'd15;
        wr_color = 24'h222222; wr_vld = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        @(posedge clk);
        #1 check("wr_same_edge_old", {1'b1, 24'h111111});
        @(posedge clk);
        #1 check("wr_next_pixel_new", {1'b1, 24'h222222});

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
